// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad scanning path.
//   - Column one-hot-low drive constants. These are also used by the column sequencer.
//   - Key-code constants and the (row,col) to code map.
//   - Frame-result and debounce-state enumerations.
package keypad_pkg;

  // Column drive patterns. Column c is driven low on bit (3-c).
  localparam logic [3:0] COL0 = 4'b0111;
  localparam logic [3:0] COL1 = 4'b1011;
  localparam logic [3:0] COL2 = 4'b1101;
  localparam logic [3:0] COL3 = 4'b1110;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;  // '*'
  localparam logic [3:0] KEY_F = 4'hF;  // '#'

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_result_e;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_QUAL   = 2'd1,
    HELD         = 2'd2,
    RELEASE_QUAL = 2'd3
  } kd_state_e;

  // Keypad legend lookup.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_E;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_F;
      4'b11_11: code = KEY_D;
      default:  code = KEY_0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_decode_sync_delay.sv
// sync_delay: an N-stage flop chain that resets to all-ones.
// It is used as a synchronizer for the asynchronous keypad rows, and as an
// equal-depth delay line for the column drive, so that both stay aligned.
//   clk, reset : clock and asynchronous active-high reset
//   din        : input vector
//   dout       : din delayed by STAGES clocks
module sync_delay #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  // Shift path: stage 0 takes the input, each later stage takes its predecessor.
  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < int'(STAGES); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Chain registers. All-ones is the idle value for both rows and columns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= {WIDTH{1'b1}};
      end
    end else begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/keypad_decode.sv
// keypad_decode: turns scanned 4x4 keypad rows into a debounced key code.
//   clk         : system clock, shared with the column sequencer
//   reset       : asynchronous active-high reset
//   kpc[3:0]    : column drive, one-hot-low
//   kpr[3:0]    : raw keypad rows, active-low and asynchronous
//   key_code    : code of the last qualified key; held after release
//   key_down    : high while a qualified key is held
//   key_press   : one-cycle pulse when a press qualifies
//   key_release : one-cycle pulse when a release qualifies
module keypad_decode
  import keypad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kpc,
  input  logic [3:0] kpr,
  output logic [3:0] key_code,
  output logic       key_down,
  output logic       key_press,
  output logic       key_release
);

  localparam logic [7:0] DEB_FRAMES = 8'(DEBOUNCE_FRAMES);

  logic [3:0] kpc_d;
  logic [3:0] kpr_s;

  sync_delay #(.STAGES(SYNC_STAGES), .WIDTH(4)) u_kpr_sync (
    .clk   (clk),
    .reset (reset),
    .din   (kpr),
    .dout  (kpr_s)
  );

  sync_delay #(.STAGES(SYNC_STAGES), .WIDTH(4)) u_kpc_delay (
    .clk   (clk),
    .reset (reset),
    .din   (kpc),
    .dout  (kpc_d)
  );

  // Per-cycle decode
  logic       col_valid_s;
  logic [1:0] col_idx_s;
  logic [1:0] row_idx_s;
  logic [2:0] row_cnt_s;

  // Frame accumulator
  logic       in_frame_q, in_frame_d;
  logic [1:0] exp_col_q, exp_col_d;
  logic [1:0] hits_q, hits_d;  // saturates at 2, which means "more than one"
  logic [3:0] first_code_q, first_code_d;
  logic       bad_q, bad_d;
  logic       frame_end_s;
  logic [2:0] hit_sum_s;
  frame_result_e frame_res_s;

  // Debounce FSM and registered outputs
  kd_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc_s;
  logic [3:0] cand_q, cand_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_down_q, key_down_d;
  logic       key_press_q, key_press_d;
  logic       key_release_q, key_release_d;

  // Column decode; a pattern that is not one-hot-low contributes nothing.
  always_comb begin
    col_valid_s = 1'b1;
    col_idx_s   = 2'd0;
    case (kpc_d)
      COL0:    col_idx_s = 2'd0;
      COL1:    col_idx_s = 2'd1;
      COL2:    col_idx_s = 2'd2;
      COL3:    col_idx_s = 2'd3;
      default: col_valid_s = 1'b0;
    endcase
  end

  // Row decode: count the low rows, and take the lowest-numbered low row as the first one.
  always_comb begin
    row_cnt_s = {2'b00, ~kpr_s[3]} + {2'b00, ~kpr_s[2]} +
                {2'b00, ~kpr_s[1]} + {2'b00, ~kpr_s[0]};
    if (!kpr_s[3]) begin
      row_idx_s = 2'd0;
    end else if (!kpr_s[2]) begin
      row_idx_s = 2'd1;
    end else if (!kpr_s[1]) begin
      row_idx_s = 2'd2;
    end else begin
      row_idx_s = 2'd3;
    end
  end

  // Frame accumulation. Col0 restarts a frame, and col3 closes it.
  // A column seen out of sequence marks the frame bad.
  always_comb begin
    in_frame_d   = in_frame_q;
    exp_col_d    = exp_col_q;
    hits_d       = hits_q;
    first_code_d = first_code_q;
    bad_d        = bad_q;
    frame_end_s  = 1'b0;
    hit_sum_s    = 3'd0;
    if (col_valid_s) begin
      if (col_idx_s == 2'd0) begin
        in_frame_d   = 1'b1;
        bad_d        = 1'b0;
        exp_col_d    = 2'd1;
        hit_sum_s    = row_cnt_s;
        first_code_d = key_map(row_idx_s, 2'd0);
      end else begin
        bad_d     = bad_q | ~in_frame_q | (exp_col_q != col_idx_s);
        exp_col_d = col_idx_s + 2'd1;
        hit_sum_s = {1'b0, hits_q} + row_cnt_s;
        if ((hits_q == 2'd0) && (row_cnt_s != 3'd0)) begin
          first_code_d = key_map(row_idx_s, col_idx_s);
        end else begin
          first_code_d = first_code_q;
        end
      end
      if (hit_sum_s >= 3'd2) begin
        hits_d = 2'd2;
      end else begin
        hits_d = hit_sum_s[1:0];
      end
      if (col_idx_s == 2'd3) begin
        frame_end_s = 1'b1;
        in_frame_d  = 1'b0;
      end else begin
        frame_end_s = 1'b0;
      end
    end else begin
      hit_sum_s = 3'd0;
    end
  end

  // Classify the frame from the values that include the current (closing) cycle.
  always_comb begin
    if (bad_d) begin
      frame_res_s = MULTI;
    end else if (hits_d == 2'd0) begin
      frame_res_s = NONE;
    end else if (hits_d == 2'd1) begin
      frame_res_s = SINGLE;
    end else begin
      frame_res_s = MULTI;
    end
  end

  // Frame accumulator registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_frame_q   <= 1'b0;
      exp_col_q    <= 2'd0;
      hits_q       <= 2'd0;
      first_code_q <= 4'd0;
      bad_q        <= 1'b0;
    end else begin
      in_frame_q   <= in_frame_d;
      exp_col_q    <= exp_col_d;
      hits_q       <= hits_d;
      first_code_q <= first_code_d;
      bad_q        <= bad_d;
    end
  end

  assign cnt_inc_s = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);

  // Debounce next-state and output logic. It advances only at a frame end.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cand_d        = cand_q;
    key_code_d    = key_code_q;
    key_down_d    = key_down_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    if (frame_end_s) begin
      case (state_q)
        IDLE: begin
          if (frame_res_s == SINGLE) begin
            cand_d = first_code_d;
            cnt_d  = 8'd1;
            if (DEB_FRAMES <= 8'd1) begin
              state_d     = HELD;
              cnt_d       = 8'd0;
              key_code_d  = first_code_d;
              key_down_d  = 1'b1;
              key_press_d = 1'b1;
            end else begin
              state_d = PRESS_QUAL;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end
        PRESS_QUAL: begin
          if ((frame_res_s == SINGLE) && (first_code_d == cand_q)) begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s >= DEB_FRAMES) begin
              state_d     = HELD;
              cnt_d       = 8'd0;
              key_code_d  = cand_q;
              key_down_d  = 1'b1;
              key_press_d = 1'b1;
            end else begin
              state_d = PRESS_QUAL;
            end
          end else if (frame_res_s == SINGLE) begin
            cand_d = first_code_d;
            cnt_d  = 8'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end
        HELD: begin
          // A second key, or a different key, never changes the held code.
          if (frame_res_s == NONE) begin
            cnt_d = 8'd1;
            if (DEB_FRAMES <= 8'd1) begin
              state_d       = IDLE;
              cnt_d         = 8'd0;
              key_down_d    = 1'b0;
              key_release_d = 1'b1;
            end else begin
              state_d = RELEASE_QUAL;
            end
          end else begin
            state_d = HELD;
          end
        end
        RELEASE_QUAL: begin
          if (frame_res_s == NONE) begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s >= DEB_FRAMES) begin
              state_d       = IDLE;
              cnt_d         = 8'd0;
              key_down_d    = 1'b0;
              key_release_d = 1'b1;
            end else begin
              state_d = RELEASE_QUAL;
            end
          end else begin
            state_d = HELD;
            cnt_d   = 8'd0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Debounce state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      cand_q        <= 4'd0;
      key_code_q    <= 4'd0;
      key_down_q    <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cand_q        <= cand_d;
      key_code_q    <= key_code_d;
      key_down_q    <= key_down_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_down    = key_down_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

endmodule
